// File: rtl/draw_addr_sweep.sv
// draw_addr_sweep: handshaked index sweep for the draw path.
// Sweeps [START_IDX, END_IDX) by STEP. Each live beat presents LANES interleaved
// bank addresses {idx, lane}. Supports one-shot or wrapping passes, plus hold and abort.
// Optional build macro SWEEP_REVERSE_EN adds the 'rev' input, which selects a
// descending sweep when a start is accepted.
module draw_addr_sweep #(
  parameter int LANES     = 2,
  parameter int IDX_W     = 13,
  parameter int LANE_W    = $clog2(LANES),
  parameter int ADDR_W    = IDX_W + LANE_W,
  parameter int START_IDX = 512,
  parameter int END_IDX   = 640,
  parameter int STEP      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hold,
  input  logic                    abort,
  input  logic                    wrap,
`ifdef SWEEP_REVERSE_EN
  input  logic                    rev,
`endif
  output logic                    busy,
  output logic                    valid,
  output logic                    done,
  output logic [IDX_W-1:0]        idx,
  output logic [LANES*ADDR_W-1:0] addr
);

  // The last index is the final reachable point of the sweep, not END_IDX-1,
  // because STEP may not divide the range evenly.
  localparam int NBEATS   = (END_IDX - START_IDX + STEP - 1) / STEP;
  localparam int LAST_IDX = START_IDX + (NBEATS - 1) * STEP;

  localparam logic [IDX_W-1:0] START_V = IDX_W'(START_IDX);
  localparam logic [IDX_W-1:0] LAST_V  = IDX_W'(LAST_IDX);
  localparam logic [IDX_W-1:0] STEP_V  = IDX_W'(STEP);

  // One extra bit keeps idx+STEP from overflowing when END_IDX == 2**IDX_W.
  localparam logic [IDX_W:0] START_X = (IDX_W+1)'(START_IDX);
  localparam logic [IDX_W:0] END_X   = (IDX_W+1)'(END_IDX);
  localparam logic [IDX_W:0] STEP_X  = (IDX_W+1)'(STEP);

  if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
    $error("draw_addr_sweep: LANES must be a power of 2 and at least 2");
  end
  if (STEP < 1) begin : g_bad_step
    $error("draw_addr_sweep: STEP must be at least 1");
  end
  if (START_IDX >= END_IDX || longint'(END_IDX) > (longint'(1) << IDX_W)) begin : g_bad_range
    $error("draw_addr_sweep: need START_IDX < END_IDX <= 2**IDX_W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] next_idx;
  logic             done_q, next_done;
  logic             last_beat;
  logic             desc;

`ifdef SWEEP_REVERSE_EN
  logic rev_q, next_rev;
  assign desc = rev_q;
`else
  assign desc = 1'b0;
`endif

  // Registers for state, index, done pulse and captured direction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= START_V;
      done_q <= 1'b0;
`ifdef SWEEP_REVERSE_EN
      rev_q  <= 1'b0;
`endif
    end else begin
      state  <= next_state;
      idx    <= next_idx;
      done_q <= next_done;
`ifdef SWEEP_REVERSE_EN
      rev_q  <= next_rev;
`endif
    end
  end

  // Detect whether the current index is the final beat of a pass in the active direction.
  always_comb begin
    if (desc) begin
      last_beat = (({1'b0, idx} - START_X) < STEP_X);
    end else begin
      last_beat = (({1'b0, idx} + STEP_X) >= END_X);
    end
  end

  // Next-state, next-index and done-pulse logic. Abort overrides everything else.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_done  = 1'b0;
`ifdef SWEEP_REVERSE_EN
    next_rev   = rev_q;
`endif
    if (abort) begin
      next_state = IDLE;
      next_idx   = START_V;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            next_state = RUN;
            next_idx   = START_V;
`ifdef SWEEP_REVERSE_EN
            next_rev   = rev;
            if (rev) begin
              next_idx = LAST_V;
            end
`endif
          end
        end
        RUN: begin
          if (!hold) begin
            if (last_beat) begin
              next_done = 1'b1;
              if (wrap) begin
                next_idx = desc ? LAST_V : START_V;
              end else begin
                next_state = FIN;
              end
            end else begin
              next_idx = desc ? (idx - STEP_V) : (idx + STEP_V);
            end
          end
        end
        FIN: begin
          next_state = IDLE;
          next_idx   = START_V;
        end
        default: begin
          next_state = IDLE;
          next_idx   = START_V;
        end
      endcase
    end
  end

  // Output decodes from registered state, plus the lane address fan-out.
  always_comb begin
    busy  = (state != IDLE);
    valid = (state == RUN) && !hold;
    done  = done_q;
    addr  = '0;
    for (int k = 0; k < LANES; k++) begin
      addr[k*ADDR_W +: ADDR_W] = {idx, LANE_W'(k)};
    end
  end

endmodule

// File: tb/tb_draw_addr_sweep.sv
// tb_draw_addr_sweep: directed checks of draw_addr_sweep.
// A default-parameter instance covers the long sweeps. A short instance
// (START 0, END 10, STEP 3) runs a per-cycle vector table.
module tb_draw_addr_sweep;

  logic clk = 1'b0;
  logic reset;

  logic start, hold, abort, wrap, rev;
  logic busy, valid, done;
  logic [12:0] idx;
  logic [27:0] addr;

  logic s2_start, s2_hold, s2_abort, s2_wrap, s2_rev;
  logic s2_busy, s2_valid, s2_done;
  logic [12:0] s2_idx;
  logic [27:0] s2_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  draw_addr_sweep dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .hold  (hold),
    .abort (abort),
    .wrap  (wrap),
`ifdef SWEEP_REVERSE_EN
    .rev   (rev),
`endif
    .busy  (busy),
    .valid (valid),
    .done  (done),
    .idx   (idx),
    .addr  (addr)
  );

  draw_addr_sweep #(
    .START_IDX (0),
    .END_IDX   (10),
    .STEP      (3)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (s2_start),
    .hold  (s2_hold),
    .abort (s2_abort),
    .wrap  (s2_wrap),
`ifdef SWEEP_REVERSE_EN
    .rev   (s2_rev),
`endif
    .busy  (s2_busy),
    .valid (s2_valid),
    .done  (s2_done),
    .idx   (s2_idx),
    .addr  (s2_addr)
  );

  typedef struct {
    logic start;
    logic hold;
    logic abort;
    logic wrap;
    logic eb;
    logic ev;
    logic ed;
    int   ei;
  } vec_t;

  vec_t vecs [17];

  task automatic checkOne(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // sel=0 checks the default instance, sel=1 the short instance.
  // The expected lane addresses are built from the expected index.
  task automatic checkOutput(input string tag, input int sel, input logic eb, input logic ev,
                             input logic ed, input int ei);
    int ea;
    ea = (((ei * 2) + 1) << 14) | (ei * 2);
    if (sel == 0) begin
      checkOne({tag, ".busy"},  int'(busy),  int'(eb));
      checkOne({tag, ".valid"}, int'(valid), int'(ev));
      checkOne({tag, ".done"},  int'(done),  int'(ed));
      checkOne({tag, ".idx"},   int'(idx),   ei);
      checkOne({tag, ".addr"},  int'(addr),  ea);
    end else begin
      checkOne({tag, ".busy"},  int'(s2_busy),  int'(eb));
      checkOne({tag, ".valid"}, int'(s2_valid), int'(ev));
      checkOne({tag, ".done"},  int'(s2_done),  int'(ed));
      checkOne({tag, ".idx"},   int'(s2_idx),   ei);
      checkOne({tag, ".addr"},  int'(s2_addr),  ea);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    s2_start = v.start;
    s2_hold  = v.hold;
    s2_abort = v.abort;
    s2_wrap  = v.wrap;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start on the default instance and leave the bench just
  // after the edge that accepts it (first beat visible this cycle).
  task automatic startSweep(input logic w, input logic r);
    tick();
    start = 1'b1;
    wrap  = w;
    rev   = r;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int beats;
    int fin_t;
    logic fin_seen;

    reset = 1'b1;
    start = 0; hold = 0; abort = 0; wrap = 0; rev = 0;
    s2_start = 0; s2_hold = 0; s2_abort = 0; s2_wrap = 0; s2_rev = 0;

    // start, hold, abort, wrap | busy, valid, done, idx
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 1, 0, 3};
    vecs[4]  = '{0, 1, 0, 0, 1, 0, 0, 6};
    vecs[5]  = '{1, 0, 0, 0, 1, 1, 0, 6};
    vecs[6]  = '{0, 0, 0, 0, 1, 1, 0, 9};
    vecs[7]  = '{0, 0, 0, 0, 1, 0, 1, 9};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 1, 0, 0, 0, 0};
    vecs[10] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 1, 1, 1, 0, 3};
    vecs[12] = '{0, 0, 0, 1, 1, 1, 0, 6};
    vecs[13] = '{0, 0, 0, 1, 1, 1, 0, 9};
    vecs[14] = '{0, 0, 0, 1, 1, 1, 1, 0};
    vecs[15] = '{0, 0, 1, 1, 1, 1, 0, 3};
    vecs[16] = '{0, 0, 0, 0, 0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("in_reset", 0, 0, 0, 0, 512);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset", 0, 0, 0, 0, 512);

    // Short instance: per-cycle vector table (step 3, hold, ignored start, wrap, abort).
    for (int i = 0; i < 17; i++) begin
      tick();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), 1, vecs[i].eb, vecs[i].ev, vecs[i].ed, vecs[i].ei);
    end

    // One-shot default sweep: 128 beats, then FIN, then idle.
    startSweep(1'b0, 1'b0);
    for (int t = 0; t < 128; t++) begin
      if (t > 0) tick();
      @(negedge clk);
      checkOutput($sformatf("oneshot_t%0d", t), 0, 1, 1, 0, 512 + t);
    end
    tick();
    @(negedge clk);
    checkOutput("oneshot_fin", 0, 1, 0, 1, 639);
    tick();
    @(negedge clk);
    checkOutput("oneshot_idle", 0, 0, 0, 0, 512);

    // Wrapping sweep: done pulses on the first beat of every new pass.
    startSweep(1'b1, 1'b0);
    for (int t = 0; t < 300; t++) begin
      if (t > 0) tick();
      @(negedge clk);
      checkOutput($sformatf("wrap_t%0d", t), 0, 1, 1, (t > 0 && (t % 128) == 0), 512 + (t % 128));
    end
    tick();
    abort = 1'b1;
    @(negedge clk);
    checkOutput("wrap_abort_cyc", 0, 1, 1, 0, 556);
    tick();
    abort = 1'b0;
    wrap  = 1'b0;
    @(negedge clk);
    checkOutput("wrap_after_abort", 0, 0, 0, 0, 512);

    // Hold for 5 cycles at index 600; the pass must still have 128 beats.
    startSweep(1'b0, 1'b0);
    beats = 0;
    fin_seen = 1'b0;
    fin_t = -1;
    for (int t = 0; t < 200 && !fin_seen; t++) begin
      if (t > 0) tick();
      hold = (t >= 88 && t <= 92);
      @(negedge clk);
      if (valid) beats++;
      if (t >= 88 && t <= 92) checkOutput($sformatf("hold_t%0d", t), 0, 1, 0, 0, 600);
      if (t == 93) checkOutput("hold_resume600", 0, 1, 1, 0, 600);
      if (t == 94) checkOutput("hold_resume601", 0, 1, 1, 0, 601);
      if (done) begin
        fin_seen = 1'b1;
        fin_t = t;
      end
    end
    hold = 1'b0;
    checkOne("hold_done_seen", int'(fin_seen), 1);
    checkOne("hold_done_cycle", fin_t, 133);
    checkOne("hold_beats", beats, 128);
    tick();
    @(negedge clk);
    checkOutput("hold_idle", 0, 0, 0, 0, 512);

    // Abort at index 550, with a start issued mid-run that must be ignored.
    startSweep(1'b0, 1'b0);
    for (int t = 0; t <= 38; t++) begin
      if (t > 0) tick();
      start = (t == 10);
      abort = (t == 38);
      @(negedge clk);
      checkOutput($sformatf("abort_t%0d", t), 0, 1, 1, 0, 512 + t);
    end
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_next", 0, 0, 0, 0, 512);
    for (int t = 0; t < 3; t++) begin
      tick();
      @(negedge clk);
      checkOutput($sformatf("abort_quiet%0d", t), 0, 0, 0, 0, 512);
    end

    // Asynchronous reset mid-sweep takes effect without a clock edge.
    startSweep(1'b0, 1'b0);
    for (int t = 0; t <= 20; t++) begin
      if (t > 0) tick();
      @(negedge clk);
    end
    checkOutput("areset_before", 0, 1, 1, 0, 532);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("areset_now", 0, 0, 0, 0, 512);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("areset_after", 0, 0, 0, 0, 512);

`ifdef SWEEP_REVERSE_EN
    // Descending one-shot sweep: 639 down to 512, FIN parks at 512.
    startSweep(1'b0, 1'b1);
    rev = 1'b0;
    for (int t = 0; t < 128; t++) begin
      if (t > 0) tick();
      @(negedge clk);
      checkOutput($sformatf("rev_t%0d", t), 0, 1, 1, 0, 639 - t);
    end
    tick();
    @(negedge clk);
    checkOutput("rev_fin", 0, 1, 0, 1, 512);
    tick();
    @(negedge clk);
    checkOutput("rev_idle", 0, 0, 0, 0, 512);

    // Descending wrap reloads the last index.
    startSweep(1'b1, 1'b1);
    rev = 1'b0;
    for (int t = 0; t < 130; t++) begin
      if (t > 0) tick();
      @(negedge clk);
      checkOutput($sformatf("revwrap_t%0d", t), 0, 1, 1, (t == 128), 639 - (t % 128));
    end
    tick();
    abort = 1'b1;
    wrap  = 1'b0;
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("revwrap_abort", 0, 0, 0, 0, 512);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
